// File: rtl/sam_pkg.sv
// Shared constants for the SAM accumulator sequencer:
// control-word bit map, opcodes and FSM state encoding.
package sam_pkg;

    localparam int unsigned CW_PC_TO_ABUS   = 21;
    localparam int unsigned CW_IR_TO_ABUS   = 20;
    localparam int unsigned CW_MBR_TO_ABUS  = 19;
    localparam int unsigned CW_RBUS_TO_AC   = 18;
    localparam int unsigned CW_AC_TO_ALUA   = 17;
    localparam int unsigned CW_MBUS_TO_ALUB = 16;
    localparam int unsigned CW_ALU_ADD      = 15;
    localparam int unsigned CW_ALU_PASSB    = 14;
    localparam int unsigned CW_MAR_TO_ADDR  = 13;
    localparam int unsigned CW_MBR_TO_DATA  = 12;
    localparam int unsigned CW_ABUS_TO_IR   = 11;
    localparam int unsigned CW_ABUS_TO_MAR  = 10;
    localparam int unsigned CW_DATA_TO_MBR  = 9;
    localparam int unsigned CW_RBUS_TO_MBR  = 8;
    localparam int unsigned CW_MBR_TO_MBUS  = 7;
    localparam int unsigned CW_PC_CLR       = 6;
    localparam int unsigned CW_PC_INC       = 5;
    localparam int unsigned CW_ABUS_TO_PC   = 4;
    localparam int unsigned CW_RW           = 3;
    localparam int unsigned CW_REQUEST      = 2;
    localparam int unsigned CW_AC_TO_RBUS   = 1;
    localparam int unsigned CW_ALU_TO_RBUS  = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    typedef enum logic [4:0] {
        S_RST  = 5'd0,
        S_FA   = 5'd1,
        S_FM   = 5'd2,
        S_FL   = 5'd3,
        S_DEC  = 5'd4,
        S_EA   = 5'd5,
        S_RM   = 5'd6,
        S_RL   = 5'd7,
        S_AX   = 5'd8,
        S_WB   = 5'd9,
        S_SR   = 5'd10,
        S_SM   = 5'd11,
        S_SW   = 5'd12,
        S_BR   = 5'd13,
        S_HALT = 5'd14
    } state_e;

    function automatic logic is_mem(state_e s);
        return (s == S_FM) || (s == S_RM) || (s == S_SW);
    endfunction

endpackage

// File: rtl/sam_cw_decode.sv
// Combinational state/opcode/sign to control-word lookup.
// The caller registers the result, so b tracks the state it is fed.
module sam_cw_decode
    import sam_pkg::*;
#(
    parameter int CW_W = 22
) (
    input  state_e            state_i,
    input  logic [1:0]        op_i,
    input  logic              ac_sign_i,
    output logic [CW_W-1:0]   cw_o
);

    always_comb begin
        cw_o = '0;
        unique case (state_i)
            S_RST: cw_o[CW_PC_CLR] = 1'b1;
            S_FA: begin
                cw_o[CW_PC_TO_ABUS]  = 1'b1;
                cw_o[CW_ABUS_TO_MAR] = 1'b1;
            end
            S_FM, S_RM: begin
                cw_o[CW_MAR_TO_ADDR] = 1'b1;
                cw_o[CW_RW]          = 1'b1;
                cw_o[CW_REQUEST]     = 1'b1;
            end
            S_FL: begin
                cw_o[CW_DATA_TO_MBR] = 1'b1;
                cw_o[CW_PC_INC]      = 1'b1;
            end
            S_DEC: begin
                cw_o[CW_MBR_TO_ABUS] = 1'b1;
                cw_o[CW_ABUS_TO_IR]  = 1'b1;
            end
            S_EA: begin
                cw_o[CW_IR_TO_ABUS]  = 1'b1;
                cw_o[CW_ABUS_TO_MAR] = 1'b1;
            end
            S_RL: cw_o[CW_DATA_TO_MBR] = 1'b1;
            S_AX: begin
                cw_o[CW_MBR_TO_MBUS]  = 1'b1;
                cw_o[CW_MBUS_TO_ALUB] = 1'b1;
                if (op_i == OP_ADD) begin
                    cw_o[CW_AC_TO_ALUA] = 1'b1;
                    cw_o[CW_ALU_ADD]    = 1'b1;
                end else begin
                    cw_o[CW_ALU_PASSB]  = 1'b1;
                end
            end
            S_WB: begin
                cw_o[CW_ALU_TO_RBUS] = 1'b1;
                cw_o[CW_RBUS_TO_AC]  = 1'b1;
                if (op_i == OP_ADD) cw_o[CW_ALU_ADD] = 1'b1;
                else                cw_o[CW_ALU_PASSB] = 1'b1;
            end
            S_SR: cw_o[CW_AC_TO_RBUS] = 1'b1;
            S_SM: cw_o[CW_RBUS_TO_MBR] = 1'b1;
            S_SW: begin
                cw_o[CW_MAR_TO_ADDR] = 1'b1;
                cw_o[CW_MBR_TO_DATA] = 1'b1;
                cw_o[CW_REQUEST]     = 1'b1;
            end
            S_BR: begin
                if (ac_sign_i) begin
                    cw_o[CW_IR_TO_ABUS] = 1'b1;
                    cw_o[CW_ABUS_TO_PC] = 1'b1;
                end
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/sam_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the SAM datapath,
// with memory WAIT handling and an optional bus timeout.
module sam_sequencer
    import sam_pkg::*;
#(
    parameter int CW_W         = 22,
    parameter int WAIT_TIMEOUT = 0,
    parameter int TO_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wait_i,
    input  logic [1:0]      ir_op,
    input  logic            ac_sign,
    output logic [CW_W-1:0] b,
    output logic            instr_done,
    output logic            bus_err,
    output logic [4:0]      state_o
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [CW_W-1:0]   b_q, b_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              timeout;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;
        timeout = 1'b0;

        if (is_mem(state_q) && wait_i) begin
            cnt_d = cnt_q + TO_W'(1);
            if (WAIT_TIMEOUT > 0 && cnt_d == TO_W'(WAIT_TIMEOUT))
                timeout = 1'b1;
        end

        unique case (state_q)
            // b is still zero on the first cycle out of reset; hold S_RST
            // one more cycle so its PC=0 word is actually presented.
            S_RST:  state_d = b_q[CW_PC_CLR] ? S_FA : S_RST;
            S_FA:   state_d = S_FM;
            S_FM:   if (!wait_i) state_d = S_FL;
            S_FL:   state_d = S_DEC;
            S_DEC: begin
                op_d    = ir_op;
                state_d = (ir_op == OP_BRN) ? S_BR : S_EA;
            end
            S_EA:   state_d = (op_q == OP_STORE) ? S_SR : S_RM;
            S_RM:   if (!wait_i) state_d = S_RL;
            S_RL:   state_d = S_AX;
            S_AX:   state_d = S_WB;
            S_WB:   state_d = S_FA;
            S_SR:   state_d = S_SM;
            S_SM:   state_d = S_SW;
            S_SW: begin
                if (!wait_i) begin
                    state_d = S_FA;
                    done_d  = 1'b1;
                end
            end
            S_BR:   state_d = S_FA;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase

        if (state_d == S_WB || state_d == S_BR)
            done_d = 1'b1;

        if (timeout) begin
            state_d = S_HALT;
            err_d   = 1'b1;
            done_d  = 1'b0;
        end
    end

    sam_cw_decode #(
        .CW_W      (CW_W)
    ) u_decode (
        .state_i   (state_d),
        .op_i      (op_d),
        .ac_sign_i (ac_sign),
        .cw_o      (b_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            op_q    <= OP_LOAD;
            cnt_q   <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign b          = b_q;
    assign instr_done = done_q;
    assign bus_err    = err_q;
    assign state_o    = state_q;

endmodule
